// File: rtl/fetch_buffer_pkg.sv
// Shared types and system defaults for the instruction-fetch buffer.
package fetch_buffer_pkg;

    localparam int XLEN     = 32;
    localparam int FB_DEPTH = 8;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } FB_ENTRY;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch PC register plus a circular {pc, inst} queue that accepts up to two
// instructions per icache hit and hands one per cycle to dispatch.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = FB_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic [XLEN-1:0]              proc2Icache_addr,
    input  logic [63:0]                  Icache_data_out,
    input  logic                         Icache_valid_out,
    input  logic                         dispatch_ready,
    output logic                         fb_valid,
    output logic [31:0]                  fb_inst,
    output logic [XLEN-1:0]              fb_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fb_count,
    output logic                         fb_full
`ifdef TEST_MODE
    ,
    output FB_ENTRY [DEPTH-1:0]          show_fb_entries,
    output logic [$clog2(DEPTH)-1:0]     head,
    output logic [$clog2(DEPTH)-1:0]     tail
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    FB_ENTRY [DEPTH-1:0] entries;
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q;
    logic [XLEN-1:0]     fetch_pc;

    logic [CW-1:0]       free;
    logic [1:0]          push_n;
    logic [XLEN-1:0]     pc_step;
    FB_ENTRY             w0, w1;
    logic                pop;

    assign proc2Icache_addr = fetch_pc;
    assign fb_count         = count_q;
    assign fb_full          = (count_q == CW'(DEPTH));
    assign fb_valid         = (count_q != '0) && !redirect_valid;
    assign fb_inst          = entries[head_q].inst;
    assign fb_pc            = entries[head_q].pc;
    assign pop              = fb_valid && dispatch_ready;

    // Space is judged on the current count only; a pop this cycle frees nothing.
    assign free = CW'(DEPTH) - count_q;

    always_comb begin
        push_n  = 2'd0;
        pc_step = '0;
        w0.inst = Icache_data_out[31:0];
        w0.pc   = fetch_pc;
        w1.inst = Icache_data_out[63:32];
        w1.pc   = fetch_pc + XLEN'(4);
        if (Icache_valid_out && !redirect_valid) begin
            if (!fetch_pc[2]) begin
                if (free >= CW'(2)) begin
                    push_n  = 2'd2;
                    pc_step = XLEN'(8);
                end else if (free == CW'(1)) begin
                    push_n  = 2'd1;
                    pc_step = XLEN'(4);
                end
            end else if (free != '0) begin
                // Odd-word PC: only the upper half of the line is ours.
                push_n  = 2'd1;
                pc_step = XLEN'(4);
                w0.inst = Icache_data_out[63:32];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entries  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (push_n != 2'd0) entries[tail_q] <= w0;
            // Second slot index wraps naturally via PW-bit arithmetic.
            if (push_n == 2'd2) entries[tail_q + PW'(1)] <= w1;
            tail_q   <= tail_q + PW'(push_n);
            head_q   <= head_q + PW'(pop);
            count_q  <= count_q + CW'(push_n) - CW'(pop);
            fetch_pc <= fetch_pc + pc_step;
        end
    end

`ifdef TEST_MODE
    assign show_fb_entries = entries;
    assign head            = head_q;
    assign tail            = tail_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fill, partial push, miss drain, wrap, redirect, reset.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache_data_out;
    logic            Icache_valid_out;
    logic            dispatch_ready;
    logic            fb_valid;
    logic [31:0]     fb_inst;
    logic [XLEN-1:0] fb_pc;
    logic [3:0]      fb_count;
    logic            fb_full;

    int nchk = 0;
    int nerr = 0;

    fetch_buffer #(.DEPTH(8), .RESET_PC('0)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .proc2Icache_addr(proc2Icache_addr),
        .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
        .dispatch_ready(dispatch_ready),
        .fb_valid(fb_valid), .fb_inst(fb_inst), .fb_pc(fb_pc),
        .fb_count(fb_count), .fb_full(fb_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_to(input logic [XLEN-1:0] pc);
        redirect_valid   = 1'b1;
        redirect_pc      = pc;
        Icache_valid_out = 1'b0;
        tick();
        redirect_valid   = 1'b0;
    endtask

    localparam logic [63:0] DA = 64'hAAAA_0001_BBBB_0000;
    localparam logic [63:0] DO = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D3 = 64'hCCCC_0003_DDDD_0002;
    localparam logic [63:0] DW = 64'h0000_00B1_0000_00B0;

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        Icache_data_out = '0; Icache_valid_out = 1'b0; dispatch_ready = 1'b0;
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", fb_count, 0);
        chk("rst_valid", fb_valid, 0);
        chk("rst_full", fb_full, 0);
        chk("rst_addr", proc2Icache_addr, 0);

        // aligned fill
        Icache_valid_out = 1'b1; Icache_data_out = DA;
        tick();
        chk("fill1_count", fb_count, 2);
        chk("fill1_addr", proc2Icache_addr, 8);
        chk("fill1_inst", fb_inst, 32'hBBBB_0000);
        chk("fill1_pc", fb_pc, 0);
        chk("fill1_valid", fb_valid, 1);
        tick(); tick(); tick();
        chk("fill4_full", fb_full, 1);
        chk("fill4_count", fb_count, 8);
        chk("fill4_addr", proc2Icache_addr, 32);
        tick();
        chk("fill5_count", fb_count, 8);
        chk("fill5_addr", proc2Icache_addr, 32);

        // redirect while full with dispatch_ready
        dispatch_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("redir_valid_same", fb_valid, 0);
        tick();
        redirect_valid = 1'b0; Icache_valid_out = 1'b0;
        chk("redir_count", fb_count, 0);
        chk("redir_addr", proc2Icache_addr, 32'h100);
        chk("redir_valid_next", fb_valid, 0);

        // odd-word start, low bits of target ignored
        dispatch_ready = 1'b0;
        redirect_to(32'h46);
        chk("odd_addr", proc2Icache_addr, 32'h44);
        Icache_valid_out = 1'b1; Icache_data_out = DO;
        tick();
        chk("odd_count", fb_count, 1);
        chk("odd_inst", fb_inst, 32'h1111_2222);
        chk("odd_pc", fb_pc, 32'h44);
        chk("odd_addr2", proc2Icache_addr, 32'h48);
        Icache_data_out = D2;
        tick(); tick(); tick();
        chk("part_pre_count", fb_count, 7);
        chk("part_pre_addr", proc2Icache_addr, 32'h60);
        tick();
        chk("part_count", fb_count, 8);
        chk("part_full", fb_full, 1);
        chk("part_addr", proc2Icache_addr, 32'h64);
        tick();
        chk("part_hold_count", fb_count, 8);
        chk("part_hold_addr", proc2Icache_addr, 32'h64);

        // miss stall with 3 queued
        redirect_to(32'h204);
        Icache_valid_out = 1'b1; Icache_data_out = D3;
        tick();
        chk("miss_q1", fb_count, 1);
        tick();
        chk("miss_q3", fb_count, 3);
        chk("miss_addr0", proc2Icache_addr, 32'h210);
        Icache_valid_out = 1'b0; dispatch_ready = 1'b1;
        chk("miss_h0_pc", fb_pc, 32'h204);
        chk("miss_h0_inst", fb_inst, 32'hCCCC_0003);
        tick();
        chk("miss_c2", fb_count, 2);
        chk("miss_h1_pc", fb_pc, 32'h208);
        chk("miss_h1_inst", fb_inst, 32'hDDDD_0002);
        tick();
        chk("miss_h2_pc", fb_pc, 32'h20C);
        tick();
        chk("miss_empty_valid", fb_valid, 0);
        tick(); tick();
        chk("miss_late_valid", fb_valid, 0);
        chk("miss_late_count", fb_count, 0);
        chk("miss_addr_hold", proc2Icache_addr, 32'h210);

        // simultaneous push/pop and tail wrap
        dispatch_ready = 1'b0;
        redirect_to(32'h300);
        Icache_valid_out = 1'b1; Icache_data_out = DW;
        tick(); tick(); tick();
        chk("wrap_c6", fb_count, 6);
        Icache_valid_out = 1'b0; dispatch_ready = 1'b1;
        tick(); tick();
        chk("wrap_c4", fb_count, 4);
        chk("wrap_h_pc", fb_pc, 32'h308);
        Icache_valid_out = 1'b1;
        tick();
        chk("pp_count", fb_count, 5);
        chk("pp_head_pc", fb_pc, 32'h30C);
        chk("pp_addr", proc2Icache_addr, 32'h320);
        dispatch_ready = 1'b0;
        tick();
        chk("wrap_c7", fb_count, 7);
        chk("wrap_addr", proc2Icache_addr, 32'h328);
        Icache_valid_out = 1'b0; dispatch_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            logic [XLEN-1:0] epc;
            epc = 32'h30C + XLEN'(4 * i);
            chk($sformatf("drain%0d_pc", i), fb_pc, epc);
            chk($sformatf("drain%0d_inst", i), fb_inst, epc[2] ? 32'hB1 : 32'hB0);
            tick();
        end
        chk("drain_count", fb_count, 0);

        // fetch PC wraps at top of address space
        dispatch_ready = 1'b0;
        redirect_to(32'hFFFF_FFF8);
        Icache_valid_out = 1'b1;
        tick();
        chk("pcwrap_count", fb_count, 2);
        chk("pcwrap_addr", proc2Icache_addr, 0);
        chk("pcwrap_pc", fb_pc, 32'hFFFF_FFF8);

        // reset beats a concurrent redirect
        redirect_to(32'h400);
        Icache_valid_out = 1'b1;
        tick(); tick();
        dispatch_ready = 1'b1;
        tick();
        chk("mid_count5", fb_count, 5);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        reset = 1'b0; redirect_valid = 1'b0; Icache_valid_out = 1'b0; dispatch_ready = 1'b0;
        chk("mid_rst_count", fb_count, 0);
        chk("mid_rst_valid", fb_valid, 0);
        chk("mid_rst_full", fb_full, 0);
        chk("mid_rst_addr", proc2Icache_addr, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
